// File: rtl/serial_to_parallel_rx.sv
// Per-lane receive deserializer. It slides over the serial stream until it finds
// the COM symbol, locks after COM_COUNT aligned COMs, then emits one byte every 8 bits.
module serial_to_parallel_rx #(
   parameter logic [7:0]  COM_CHAR  = 8'hBC,
   parameter int unsigned COM_COUNT = 4
) (
   input  logic       clk32f,
   input  logic       reset,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       active
);

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      LOCKING = 2'd1,
      ACTIVE  = 2'd2
   } state_t;

   localparam logic [3:0] LP_COM_COUNT = 4'(COM_COUNT);

   state_t     r_state;
   // Only the seven most recent bits are stored, because the incoming bit completes the candidate byte.
   logic [6:0] r_sr;
   logic [2:0] r_bit_cnt;
   logic [3:0] r_bc_cnt;
   logic [7:0] r_data_out;
   logic       r_valid_out;
   logic       r_active;

   logic [7:0] w_nb;
   logic       w_is_com;
   logic       w_byte_done;
   logic [3:0] w_bc_next;

   assign w_nb        = {r_sr, data_in};
   assign w_is_com    = (w_nb == COM_CHAR);
   assign w_byte_done = (r_bit_cnt == 3'd7);
   assign w_bc_next   = (r_bc_cnt == LP_COM_COUNT) ? r_bc_cnt : r_bc_cnt + 4'd1;

   always_ff @(posedge clk32f or negedge reset) begin
      if (!reset) begin
         r_state     <= SEARCH;
         r_sr        <= '0;
         r_bit_cnt   <= '0;
         r_bc_cnt    <= '0;
         r_data_out  <= '0;
         r_valid_out <= 1'b0;
         r_active    <= 1'b0;
      end else begin
         r_sr <= w_nb[6:0];
         case (r_state)
            SEARCH: begin
               if (w_is_com) begin
                  r_bit_cnt <= '0;
                  r_bc_cnt  <= 4'd1;
                  if (LP_COM_COUNT == 4'd1) begin
                     r_state  <= ACTIVE;
                     r_active <= 1'b1;
                  end else begin
                     r_state <= LOCKING;
                  end
               end
            end
            LOCKING: begin
               r_bit_cnt <= r_bit_cnt + 3'd1;
               if (w_byte_done) begin
                  if (w_is_com) begin
                     r_bc_cnt <= w_bc_next;
                     if (w_bc_next == LP_COM_COUNT) begin
                        r_state  <= ACTIVE;
                        r_active <= 1'b1;
                     end
                  end else begin
                     // The failing byte is dropped; sliding restarts on the next bit.
                     r_bc_cnt <= '0;
                     r_state  <= SEARCH;
                  end
               end
            end
            ACTIVE: begin
               r_bit_cnt <= r_bit_cnt + 3'd1;
               if (w_byte_done) begin
                  if (w_is_com) begin
                     r_valid_out <= 1'b0;
                  end else begin
                     r_data_out  <= w_nb;
                     r_valid_out <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= SEARCH;
            end
         endcase
      end
   end

   assign data_out  = r_data_out;
   assign valid_out = r_valid_out;
   assign active    = r_active;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Bench for serial_to_parallel_rx: directed byte tables, hand sequences for reset and
// COM_COUNT=1, then a random stream checked against a boundary-arithmetic reference model.
module tb_serial_to_parallel_rx;

   localparam logic [7:0] COM = 8'hBC;

   logic       clk32f = 1'b0;
   logic       reset  = 1'b0;
   logic       data_in = 1'b0;
   logic [7:0] d4, d1;
   logic       v4, v1, a4, a1;

   int checks = 0;
   int errors = 0;

   always #5 clk32f = ~clk32f;

   serial_to_parallel_rx #(.COM_CHAR(COM), .COM_COUNT(4)) dut4 (
      .clk32f(clk32f), .reset(reset), .data_in(data_in),
      .data_out(d4), .valid_out(v4), .active(a4)
   );

   serial_to_parallel_rx #(.COM_CHAR(COM), .COM_COUNT(1)) dut1 (
      .clk32f(clk32f), .reset(reset), .data_in(data_in),
      .data_out(d1), .valid_out(v1), .active(a1)
   );

   // Reference model: the lock boundary is remembered as an absolute bit index and
   // byte ends are found by modular distance from it.
   typedef struct {
      int         st;      // 0 searching, 1 counting COMs, 2 locked
      int         anchor;
      int         coms;
      logic [7:0] d;
      logic       v;
      logic       a;
   } mdl_t;

   mdl_t       m4, m1;
   logic [7:0] hist;
   int         t;

   function automatic mdl_t mstep(input mdl_t m, input logic [7:0] nb, input int tt, input int cc);
      bit bnd;
      bnd = (m.st != 0) && (((tt - m.anchor) % 8) == 0);
      if (m.st == 0) begin
         if (nb == COM) begin
            m.anchor = tt;
            m.coms   = 1;
            if (cc == 1) begin m.st = 2; m.a = 1'b1; end
            else m.st = 1;
         end
      end else if (bnd) begin
         if (m.st == 1) begin
            if (nb == COM) begin
               m.coms++;
               if (m.coms == cc) begin m.st = 2; m.a = 1'b1; end
            end else begin
               m.st = 0;
               m.coms = 0;
            end
         end else begin
            if (nb != COM) begin m.d = nb; m.v = 1'b1; end
            else m.v = 1'b0;
         end
      end
      return m;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string name, input bit sel1,
                          input logic [7:0] ed, input logic ev, input logic ea);
      if (sel1) begin
         chk({name, ".data"},  d1, ed);
         chk({name, ".valid"}, {7'd0, v1}, {7'd0, ev});
         chk({name, ".active"},{7'd0, a1}, {7'd0, ea});
      end else begin
         chk({name, ".data"},  d4, ed);
         chk({name, ".valid"}, {7'd0, v4}, {7'd0, ev});
         chk({name, ".active"},{7'd0, a4}, {7'd0, ea});
      end
   endtask

   task automatic step(input logic b);
      data_in = b;
      @(posedge clk32f);
      #1;
      hist = {hist[6:0], b};
      t++;
      m4 = mstep(m4, hist, t, 4);
      m1 = mstep(m1, hist, t, 1);
   endtask

   // Asserts reset between edges, checks the asynchronous clear, holds for n edges.
   task automatic do_reset(input int n);
      reset = 1'b0;
      #1;
      chk_out("rst_async4", 1'b0, 8'h00, 1'b0, 1'b0);
      chk_out("rst_async1", 1'b1, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) begin
         data_in = 1'($urandom);
         @(posedge clk32f);
         #1;
         chk_out("rst_hold4", 1'b0, 8'h00, 1'b0, 1'b0);
         chk_out("rst_hold1", 1'b1, 8'h00, 1'b0, 1'b0);
      end
      reset = 1'b1;
      hist  = 8'h00;
      t     = 0;
      m4    = '{default: 0};
      m1    = '{default: 0};
   endtask

   // Sends a byte MSB first; the previous outputs must hold until the last bit.
   task automatic send_byte(input string name, input bit sel1, input logic [7:0] b,
                            input logic [7:0] pd, input logic pv, input logic pa,
                            input logic [7:0] ed, input logic ev, input logic ea);
      for (int i = 7; i >= 0; i--) begin
         step(b[i]);
         if (i > 0) chk_out({name, "_hold"}, sel1, pd, pv, pa);
         else       chk_out(name, sel1, ed, ev, ea);
      end
   endtask

   typedef struct {
      logic       rst;
      int         nj;
      logic [2:0] jb;
      logic [7:0] b;
      logic [7:0] d;
      logic       v;
      logic       a;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic [7:0] pd;
      logic       pv, pa;

      // Lock from a misaligned start, then four data bytes.
      tbl.push_back('{1'b1, 3, 3'b101, COM,   8'h00, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 0, 3'b000, COM,   8'h00, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 0, 3'b000, COM,   8'h00, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 0, 3'b000, COM,   8'h00, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 0, 3'b000, 8'hFF, 8'hFF, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 0, 3'b000, 8'hEE, 8'hEE, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 0, 3'b000, 8'hDD, 8'hDD, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 0, 3'b000, 8'hCC, 8'hCC, 1'b1, 1'b1});
      // Broken lock sequence.
      tbl.push_back('{1'b1, 0, 3'b000, COM,   8'h00, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 0, 3'b000, COM,   8'h00, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 0, 3'b000, 8'h55, 8'h00, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 0, 3'b000, COM,   8'h00, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 0, 3'b000, COM,   8'h00, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 0, 3'b000, COM,   8'h00, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 0, 3'b000, COM,   8'h00, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 0, 3'b000, 8'hBB, 8'hBB, 1'b1, 1'b1});
      // Idle COM inserted between data bytes.
      tbl.push_back('{1'b1, 0, 3'b000, COM,   8'h00, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 0, 3'b000, COM,   8'h00, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 0, 3'b000, COM,   8'h00, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 0, 3'b000, COM,   8'h00, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 0, 3'b000, 8'hAA, 8'hAA, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 0, 3'b000, COM,   8'hAA, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 0, 3'b000, 8'h99, 8'h99, 1'b1, 1'b1});

      hist = 8'h00; t = 0;
      m4 = '{default: 0};
      m1 = '{default: 0};
      @(posedge clk32f); #1;
      do_reset(6);

      pd = 8'h00; pv = 1'b0; pa = 1'b0;
      foreach (tbl[k]) begin
         if (tbl[k].rst) begin
            do_reset(2);
            pd = 8'h00; pv = 1'b0; pa = 1'b0;
         end
         for (int j = tbl[k].nj - 1; j >= 0; j--) begin
            step(tbl[k].jb[j]);
            chk_out("tbl_junk", 1'b0, pd, pv, pa);
         end
         send_byte($sformatf("tbl%0d", k), 1'b0, tbl[k].b, pd, pv, pa,
                   tbl[k].d, tbl[k].v, tbl[k].a);
         pd = tbl[k].d; pv = tbl[k].v; pa = tbl[k].a;
      end

      // Reset in the middle of a data byte while locked.
      do_reset(2);
      send_byte("r5_c0", 1'b0, COM, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      send_byte("r5_c1", 1'b0, COM, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      send_byte("r5_c2", 1'b0, COM, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      send_byte("r5_c3", 1'b0, COM, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      send_byte("r5_d",  1'b0, 8'h42, 8'h00, 1'b0, 1'b1, 8'h42, 1'b1, 1'b1);
      for (int i = 7; i >= 4; i--) begin
         step(1'(8'h88 >> i));
         chk_out("r5_part", 1'b0, 8'h42, 1'b1, 1'b1);
      end
      do_reset(2);
      for (int i = 3; i >= 0; i--) begin
         step(1'(8'h88 >> i));
         chk_out("r5_tail", 1'b0, 8'h00, 1'b0, 1'b0);
      end
      send_byte("r5_n0", 1'b0, COM, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      send_byte("r5_n1", 1'b0, COM, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      send_byte("r5_n2", 1'b0, COM, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      send_byte("r5_n3", 1'b0, COM, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

      // Single-COM lock instance.
      do_reset(2);
      send_byte("c1_com", 1'b1, COM,   8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      send_byte("c1_d",   1'b1, 8'h77, 8'h00, 1'b0, 1'b1, 8'h77, 1'b1, 1'b1);

      // Random stream against the reference model, both instances.
      do_reset(2);
      for (int seg = 0; seg < 60; seg++) begin
         int nj, nc, nd;
         logic [7:0] b;
         if ($urandom_range(0, 9) == 0) do_reset(2);
         nj = $urandom_range(0, 7);
         nc = $urandom_range(0, 5);
         nd = $urandom_range(1, 6);
         for (int i = 0; i < nj; i++) begin
            step(1'($urandom));
            chk_out("rnd4", 1'b0, m4.d, m4.v, m4.a);
            chk_out("rnd1", 1'b1, m1.d, m1.v, m1.a);
         end
         for (int n = 0; n < nc + nd; n++) begin
            if (n < nc || $urandom_range(0, 4) == 0) b = COM;
            else b = 8'($urandom);
            for (int i = 7; i >= 0; i--) begin
               step(b[i]);
               chk_out("rnd4", 1'b0, m4.d, m4.v, m4.a);
               chk_out("rnd1", 1'b1, m1.d, m1.v, m1.a);
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_to_parallel_rx.md
Name: serial_to_parallel_rx

Overview:
- Receive-side lane stage. It sits downstream of the per-lane parallel-to-serial transmitter and upstream of the byte un-striping logic.
- Takes one serial bit per clk32f cycle, finds byte alignment by detecting the COM symbol, and locks once COM_COUNT consecutive aligned COMs have been seen.
- After lock, delivers 8-bit data bytes with a valid flag at the 1/8 bit rate (clk4f cadence).
- One instance per lane.

Parameters:
- COM_CHAR, 8'hBC, alignment/idle symbol.
- COM_COUNT, 4, consecutive aligned COM bytes required to enter ACTIVE (range 1..15).

Ports:
- clk32f  input  1  bit-rate clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- data_in  input  1  serial bit, MSB of each byte first.
- data_out  output  8  recovered byte.
- valid_out  output  1  data_out holds a non-COM byte.
- active  output  1  lane is byte-locked (state ACTIVE).

Behaviour:
- Reset: while reset=0, all registers clear asynchronously: shift register sr=0, bit_cnt=0, bc_cnt=0, state=SEARCH, data_out=8'h00, valid_out=0, active=0. Reset asserted mid-operation discards any partial byte and drops lock immediately.
- Shift: every edge out of reset, sr <= {sr[6:0], data_in}. The candidate byte at an edge is nb = {sr[6:0], data_in}.
- States are SEARCH, LOCKING and ACTIVE, with a 2-bit encoding.
- SEARCH:
  - Compare nb to COM_CHAR on every edge (bit-sliding search).
  - On match: bit_cnt <= 0, bc_cnt <= 1. If COM_COUNT==1, go to ACTIVE; otherwise go to LOCKING.
  - The match edge is the byte boundary.
- Byte-complete event: in LOCKING and ACTIVE, bit_cnt increments mod 8 on every edge. The edge where bit_cnt==7 samples the 8th bit of the next byte, and nb is that byte.
- LOCKING:
  - On byte-complete with nb==COM_CHAR: bc_cnt++. When the incremented value equals COM_COUNT, go to ACTIVE.
  - On byte-complete with nb!=COM_CHAR: bc_cnt <= 0 and return to SEARCH. Bit sliding resumes from the next edge; the failing byte is not rechecked as a COM.
  - No data output while LOCKING.
- ACTIVE:
  - active=1, registered, asserted on the edge of the entering transition.
  - On byte-complete with nb!=COM_CHAR: data_out <= nb, valid_out <= 1.
  - On byte-complete with nb==COM_CHAR (idle filler): valid_out <= 0 and data_out holds its previous value.
  - Outputs change only on byte-complete edges, so each value is held exactly 8 clk32f cycles.
  - ACTIVE is left only by reset. No loss-of-lock detection in this block.
- Latency: data_out/valid_out update on the same edge that samples the byte's last bit (0 extra cycles).
- Simultaneous events: reset dominates everything. The COM that completes COM_COUNT is never output as data.
- bc_cnt is 4 bits wide and saturates at COM_COUNT.

Test Plan:
1. Reset: hold reset=0 for 6 clk32f edges while toggling data_in. Required: data_out=8'h00, valid_out=0, active=0 throughout.
2. Lock with misaligned start: release reset, send 3 junk bits 101, then 4×8'hBC, then 8'hFF, 8'hEE, 8'hDD, 8'hCC.
   - active rises on the 8th bit of the 4th BC.
   - data_out is FF, then EE, DD, CC, each appearing on its byte's last-bit edge and held 8 cycles, with valid_out=1.
3. Broken lock sequence: send BC, BC, 8'h55, then 4×BC, then 8'hBB. Required: active stays 0 through the 55 and rises only after the later 4 BCs; then data_out=BB, valid_out=1.
4. Idle insertion in ACTIVE: after lock, send AA, BC, 99. Required:
   - AA: data_out=AA, valid_out=1.
   - BC: valid_out=0 and data_out stays AA for 8 cycles.
   - 99: data_out=99, valid_out=1.
5. Reset mid-byte: in ACTIVE, after 4 bits of 8'h88, assert reset for 2 cycles, then release. Required: outputs return to 0 asynchronously; 88 is never output; a fresh 4×BC sequence is needed before active=1.
6. COM_COUNT=1 instance: a single 8'hBC followed by 8'h77. Required: active=1 at the BC's last bit; next byte gives data_out=77, valid_out=1.
